ball_serve_ctrl: RTL and testbench

Parametrised successor to the fixed 2-player / 3-or-5-ball serve logic. Tracks per-player remaining balls for up to MAX_PLAYERS, rotates turns and skips eliminated players. Enforces a frame-counted serve-wait window and auto-serves in attract mode. Sits between the game-start/coin logic and the ball motion/video logic, clocked by CLK_DRV.

---
 rtl/breakout_pkg.sv | 28 ++
 rtl/ball_serve_ctrl_serve_timer.sv | 41 ++++
 rtl/ball_serve_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_ball_serve_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared types, default frame constants and port-width helpers for the breakout serve logic.
package breakout_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_WAIT,
        IN_PLAY
    } serve_state_t;

    localparam int DEFAULT_MAX_PLAYERS        = 4;
    localparam int DEFAULT_MAX_BALLS          = 9;
    localparam int DEFAULT_SERVE_DELAY_FRAMES = 32;
    localparam int DEFAULT_AUTO_SERVE_FRAMES  = 64;

    // Player index width; never narrower than one bit, even for a single player.
    function automatic int calc_pw(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

    function automatic int calc_bw(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ball_serve_ctrl_serve_timer.sv
// Saturating frame counter for the serve-wait window with manual and automatic serve thresholds.
module serve_timer
    import breakout_pkg::*;
#(
    parameter int  DELAY_FRAMES = DEFAULT_SERVE_DELAY_FRAMES,
    parameter int  AUTO_FRAMES  = DEFAULT_AUTO_SERVE_FRAMES,
    localparam int SAT_FRAMES   = max_int(DELAY_FRAMES, AUTO_FRAMES),
    localparam int CW           = $clog2(SAT_FRAMES + 1)
) (
    input  logic CLK_DRV,
    input  logic RESET,
    input  logic clr,
    input  logic tick,
    output logic manual_ok,
    output logic auto_ok
);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (tick && (cnt_reg != CW'(SAT_FRAMES))) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge CLK_DRV) begin
        if (RESET) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign manual_ok = (cnt_reg >= CW'(DELAY_FRAMES));
    assign auto_ok   = (cnt_reg >= CW'(AUTO_FRAMES));

endmodule

// File: rtl/ball_serve_ctrl.sv
// Serve/turn controller: per-player ball counts, turn rotation skipping eliminated players,
// serve-wait window with attract-mode auto serve.
module ball_serve_ctrl
    import breakout_pkg::*;
#(
    parameter int  MAX_PLAYERS        = DEFAULT_MAX_PLAYERS,
    parameter int  MAX_BALLS          = DEFAULT_MAX_BALLS,
    parameter int  SERVE_DELAY_FRAMES = DEFAULT_SERVE_DELAY_FRAMES,
    parameter int  AUTO_SERVE_FRAMES  = DEFAULT_AUTO_SERVE_FRAMES,
    localparam int PW                 = calc_pw(MAX_PLAYERS),
    localparam int BW                 = calc_bw(MAX_BALLS)
) (
    input  logic          CLK_DRV,
    input  logic          RESET,
    input  logic          FRAME_TICK,
    input  logic          START_GAME,
    input  logic [PW-1:0] NUM_PLAYERS_SEL,
    input  logic [BW-1:0] BALLS_SEL,
    input  logic          ATTRACT,
    input  logic          SERVE,
    input  logic          BALL,
    input  logic          BALL_LOST,
    input  logic          EXTRA_BALL,
    output logic [PW-1:0] PLAYER,
    output logic [BW-1:0] BALLS_LEFT,
    output logic          SERVE_WAIT,
    output logic          SERVE_WAIT_N,
    output logic          BALL_DISPLAY,
    output logic          SBD_N,
    output logic          EGL,
    output logic          PLAYER_CHANGE
);

    localparam logic [BW-1:0] MAX_BALLS_V = BW'(MAX_BALLS);

    // The SERVE_WAIT port shadows the imported enum member, so states are named explicitly.
    serve_state_t  state_reg, state_next;
    logic [PW-1:0] player_reg, player_next;
    logic [PW-1:0] last_reg, last_next;
    logic [BW-1:0] count_reg [MAX_PLAYERS];
    logic [BW-1:0] count_next [MAX_PLAYERS];
    logic          player_change_reg, player_change_next;

    logic          manual_ok, auto_ok, timer_clr;
    logic          extra_ok;
    logic [BW-1:0] cur_count, inc_count, after_loss;
    logic [BW-1:0] balls_clamped;
    logic [PW-1:0] last_clamped;
    logic [MAX_PLAYERS-1:0] nz_after;
    logic [PW:0]   search;

    // First player after cur (wrapping through cur itself) with balls left; MSB = found.
    function automatic logic [PW:0] find_next(input logic [MAX_PLAYERS-1:0] nz,
                                              input logic [PW-1:0] cur,
                                              input logic [PW-1:0] last);
        logic [PW-1:0] j;
        logic [PW-1:0] idx;
        logic          found;
        j     = cur;
        idx   = cur;
        found = 1'b0;
        for (int k = 0; k < MAX_PLAYERS; k++) begin
            j = (j == last) ? '0 : j + 1'b1;
            if (!found && nz[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
        return {found, idx};
    endfunction

    serve_timer #(
        .DELAY_FRAMES(SERVE_DELAY_FRAMES),
        .AUTO_FRAMES (AUTO_SERVE_FRAMES)
    ) u_serve_timer (
        .CLK_DRV  (CLK_DRV),
        .RESET    (RESET),
        .clr      (timer_clr),
        .tick     (FRAME_TICK),
        .manual_ok(manual_ok),
        .auto_ok  (auto_ok)
    );

    // Held clear outside serve-wait so the tick on the entry cycle is never counted.
    assign timer_clr = (state_reg != breakout_pkg::SERVE_WAIT) || START_GAME;

    assign balls_clamped = (BALLS_SEL == '0) ? BW'(1) :
                           (int'(BALLS_SEL) > MAX_BALLS) ? MAX_BALLS_V : BALLS_SEL;
    assign last_clamped  = (int'(NUM_PLAYERS_SEL) >= MAX_PLAYERS) ? PW'(MAX_PLAYERS - 1)
                                                                  : NUM_PLAYERS_SEL;

    assign extra_ok   = EXTRA_BALL && !ATTRACT && (state_reg != breakout_pkg::IDLE);
    assign cur_count  = count_reg[player_reg];
    assign inc_count  = (cur_count == MAX_BALLS_V) ? cur_count : cur_count + 1'b1;
    // An extra ball in the same cycle as a loss cancels the decrement.
    assign after_loss = (extra_ok || cur_count == '0) ? cur_count : cur_count - 1'b1;

    generate
        for (genvar gi = 0; gi < MAX_PLAYERS; gi++) begin : g_nz
            assign nz_after[gi] = (PW'(gi) == player_reg) ? (after_loss != '0)
                                                          : (count_reg[gi] != '0);
        end
    endgenerate

    assign search = find_next(nz_after, player_reg, last_reg);

    always_comb begin
        state_next         = state_reg;
        player_next        = player_reg;
        last_next          = last_reg;
        player_change_next = 1'b0;
        for (int i = 0; i < MAX_PLAYERS; i++) begin
            count_next[i] = count_reg[i];
        end

        if (START_GAME) begin
            last_next = last_clamped;
            for (int i = 0; i < MAX_PLAYERS; i++) begin
                count_next[i] = (i <= int'(last_clamped)) ? balls_clamped : '0;
            end
            player_next        = '0;
            player_change_next = (player_reg != '0);
            state_next         = breakout_pkg::SERVE_WAIT;
        end else begin
            case (state_reg)
                breakout_pkg::SERVE_WAIT: begin
                    if (extra_ok) begin
                        count_next[player_reg] = inc_count;
                    end
                    if ((SERVE && manual_ok) || (ATTRACT && auto_ok)) begin
                        state_next = breakout_pkg::IN_PLAY;
                    end
                end
                breakout_pkg::IN_PLAY: begin
                    if (BALL_LOST) begin
                        if (ATTRACT) begin
                            state_next = breakout_pkg::SERVE_WAIT;
                        end else begin
                            count_next[player_reg] = after_loss;
                            if (search[PW]) begin
                                state_next         = breakout_pkg::SERVE_WAIT;
                                player_next        = search[PW-1:0];
                                player_change_next = (search[PW-1:0] != player_reg);
                            end else begin
                                state_next = breakout_pkg::IDLE;
                            end
                        end
                    end else if (extra_ok) begin
                        count_next[player_reg] = inc_count;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_DRV) begin
        if (RESET) begin
            state_reg         <= breakout_pkg::IDLE;
            player_reg        <= '0;
            last_reg          <= '0;
            player_change_reg <= 1'b0;
            for (int i = 0; i < MAX_PLAYERS; i++) begin
                count_reg[i] <= '0;
            end
        end else begin
            state_reg         <= state_next;
            player_reg        <= player_next;
            last_reg          <= last_next;
            player_change_reg <= player_change_next;
            for (int i = 0; i < MAX_PLAYERS; i++) begin
                count_reg[i] <= count_next[i];
            end
        end
    end

    assign PLAYER        = player_reg;
    assign BALLS_LEFT    = cur_count;
    assign SERVE_WAIT    = (state_reg == breakout_pkg::SERVE_WAIT);
    assign SERVE_WAIT_N  = ~SERVE_WAIT;
    assign EGL           = (state_reg == breakout_pkg::IDLE);
    assign PLAYER_CHANGE = player_change_reg;
    assign BALL_DISPLAY  = (state_reg == breakout_pkg::IN_PLAY) && BALL;
    assign SBD_N         = ~(SERVE_WAIT && SERVE);

endmodule

// File: tb/tb_ball_serve_ctrl.sv
// Directed bench for ball_serve_ctrl: cycle-by-cycle comparison against a rule-level model,
// plus hand-computed checkpoints along each scenario.
module tb_ball_serve_ctrl;

    localparam int MAXP = 4;
    localparam int MAXB = 9;
    localparam int DLY  = 32;
    localparam int AUTO = 64;
    localparam int PW   = 2;
    localparam int BW   = 4;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_PLAY = 2;

    logic          CLK_DRV = 1'b0;
    logic          RESET = 1'b1;
    logic          FRAME_TICK = 1'b0;
    logic          START_GAME = 1'b0;
    logic [PW-1:0] NUM_PLAYERS_SEL = '0;
    logic [BW-1:0] BALLS_SEL = '0;
    logic          ATTRACT = 1'b0;
    logic          SERVE = 1'b0;
    logic          BALL = 1'b0;
    logic          BALL_LOST = 1'b0;
    logic          EXTRA_BALL = 1'b0;
    logic [PW-1:0] PLAYER;
    logic [BW-1:0] BALLS_LEFT;
    logic          SERVE_WAIT, SERVE_WAIT_N, BALL_DISPLAY, SBD_N, EGL, PLAYER_CHANGE;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    ball_serve_ctrl dut (
        .CLK_DRV        (CLK_DRV),
        .RESET          (RESET),
        .FRAME_TICK     (FRAME_TICK),
        .START_GAME     (START_GAME),
        .NUM_PLAYERS_SEL(NUM_PLAYERS_SEL),
        .BALLS_SEL      (BALLS_SEL),
        .ATTRACT        (ATTRACT),
        .SERVE          (SERVE),
        .BALL           (BALL),
        .BALL_LOST      (BALL_LOST),
        .EXTRA_BALL     (EXTRA_BALL),
        .PLAYER         (PLAYER),
        .BALLS_LEFT     (BALLS_LEFT),
        .SERVE_WAIT     (SERVE_WAIT),
        .SERVE_WAIT_N   (SERVE_WAIT_N),
        .BALL_DISPLAY   (BALL_DISPLAY),
        .SBD_N          (SBD_N),
        .EGL            (EGL),
        .PLAYER_CHANGE  (PLAYER_CHANGE)
    );

    always #5 CLK_DRV = ~CLK_DRV;

    // Rule-level model: mode, whose turn, balls per player, frames seen in serve-wait.
    int m_mode = M_IDLE;
    int m_player = 0;
    int m_frames = 0;
    int m_n = 1;
    int m_count [MAXP];
    bit m_change = 1'b0;

    always @(posedge CLK_DRV) begin
        int q;
        int b;
        bit found;
        bit ex;
        bit served;
        m_change = 1'b0;
        if (RESET) begin
            m_mode = M_IDLE; m_player = 0; m_frames = 0; m_n = 1;
            for (int i = 0; i < MAXP; i++) m_count[i] = 0;
        end else if (START_GAME) begin
            m_n = (int'(NUM_PLAYERS_SEL) + 1 > MAXP) ? MAXP : int'(NUM_PLAYERS_SEL) + 1;
            b = (BALLS_SEL == 0) ? 1 : ((int'(BALLS_SEL) > MAXB) ? MAXB : int'(BALLS_SEL));
            for (int i = 0; i < MAXP; i++) m_count[i] = (i < m_n) ? b : 0;
            m_change = (m_player != 0);
            m_player = 0; m_mode = M_WAIT; m_frames = 0;
        end else begin
            ex = EXTRA_BALL && !ATTRACT && (m_mode != M_IDLE);
            if (m_mode == M_WAIT) begin
                served = (SERVE && m_frames >= DLY) || (ATTRACT && m_frames >= AUTO);
                if (FRAME_TICK) m_frames++;
                if (ex && m_count[m_player] < MAXB) m_count[m_player]++;
                if (served) m_mode = M_PLAY;
            end else if (m_mode == M_PLAY) begin
                if (BALL_LOST && ATTRACT) begin
                    m_mode = M_WAIT; m_frames = 0;
                end else if (BALL_LOST) begin
                    if (!ex) m_count[m_player]--;
                    found = 1'b0; q = 0;
                    for (int k = 1; k <= m_n; k++) begin
                        if (!found && m_count[(m_player + k) % m_n] > 0) begin
                            found = 1'b1; q = (m_player + k) % m_n;
                        end
                    end
                    if (found) begin
                        m_change = (q != m_player);
                        m_player = q; m_mode = M_WAIT; m_frames = 0;
                    end else begin
                        m_mode = M_IDLE;
                    end
                end else if (ex && m_count[m_player] < MAXB) begin
                    m_count[m_player]++;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK_DRV) begin
        if (check_en) begin
            chk("player", int'(PLAYER), m_player);
            chk("balls_left", int'(BALLS_LEFT), m_count[m_player]);
            chk("serve_wait", int'(SERVE_WAIT), int'(m_mode == M_WAIT));
            chk("serve_wait_n", int'(SERVE_WAIT_N), int'(m_mode != M_WAIT));
            chk("egl", int'(EGL), int'(m_mode == M_IDLE));
            chk("player_change", int'(PLAYER_CHANGE), int'(m_change));
            chk("ball_display", int'(BALL_DISPLAY), int'(m_mode == M_PLAY && BALL));
            chk("sbd_n", int'(SBD_N), int'(!(m_mode == M_WAIT && SERVE)));
        end
    end

    task automatic step(input logic sg, input logic sv, input logic bl, input logic eb,
                        input logic ft);
        @(posedge CLK_DRV);
        #2;
        START_GAME = sg; SERVE = sv; BALL_LOST = bl; EXTRA_BALL = eb; FRAME_TICK = ft;
    endtask

    task automatic settle();
        step(0, 0, 0, 0, 0);
        @(negedge CLK_DRV);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
    endtask

    task automatic serve_ball();
        frames(DLY);
        step(0, 1, 0, 0, 0);
        settle();
    endtask

    task automatic lose();
        step(0, 0, 1, 0, 0);
        settle();
    endtask

    task automatic start(input int np, input int nb);
        NUM_PLAYERS_SEL = PW'(np);
        BALLS_SEL = BW'(nb);
        step(1, 0, 0, 0, 0);
        settle();
    endtask

    initial begin
        int exp_player [7] = '{1, 2, 0, 1, 2, 1, 1};
        int exp_balls  [7] = '{2, 2, 1, 2, 1, 1, 0};
        int exp_change [7] = '{1, 1, 1, 1, 1, 1, 0};

        // Reset values
        repeat (2) @(posedge CLK_DRV);
        #2 check_en = 1'b1;
        @(negedge CLK_DRV);
        chk("rst_player", int'(PLAYER), 0);
        chk("rst_balls", int'(BALLS_LEFT), 0);
        chk("rst_serve_wait", int'(SERVE_WAIT), 0);
        chk("rst_serve_wait_n", int'(SERVE_WAIT_N), 1);
        chk("rst_egl", int'(EGL), 1);
        chk("rst_change", int'(PLAYER_CHANGE), 0);
        @(posedge CLK_DRV);
        #2 RESET = 1'b0;

        // Single player, three balls; early serve ignored, serve at frame 32 accepted
        start(0, 3);
        chk("s1_balls", int'(BALLS_LEFT), 3);
        chk("s1_egl", int'(EGL), 0);
        step(0, 0, 1, 0, 0);
        frames(10);
        step(0, 1, 0, 0, 0);
        @(negedge CLK_DRV);
        chk("s1_sbd_n", int'(SBD_N), 0);
        settle();
        chk("s1_early_serve", int'(SERVE_WAIT), 1);
        frames(DLY - 10);
        step(0, 1, 0, 0, 0);
        settle();
        chk("s1_served", int'(SERVE_WAIT), 0);
        BALL = 1'b1;
        @(negedge CLK_DRV);
        chk("s1_ball_display", int'(BALL_DISPLAY), 1);
        BALL = 1'b0;
        lose();
        chk("s1_loss1", int'(BALLS_LEFT), 2);
        serve_ball();
        lose();
        chk("s1_loss2", int'(BALLS_LEFT), 1);
        serve_ball();
        lose();
        chk("s1_loss3", int'(BALLS_LEFT), 0);
        chk("s1_egl_end", int'(EGL), 1);
        chk("s1_idle", int'(SERVE_WAIT), 0);
        step(0, 0, 0, 1, 0);
        settle();
        chk("s1_idle_extra", int'(BALLS_LEFT), 0);

        // Three players, two balls, one extra for player 1
        start(2, 2);
        for (int i = 0; i < 7; i++) begin
            serve_ball();
            lose();
            chk("s3_player", int'(PLAYER), exp_player[i]);
            chk("s3_balls", int'(BALLS_LEFT), exp_balls[i]);
            chk("s3_change", int'(PLAYER_CHANGE), exp_change[i]);
            chk("s3_egl", int'(EGL), (i == 6) ? 1 : 0);
            if (i == 0) begin
                step(0, 0, 0, 1, 0);
                settle();
                chk("s3_extra", int'(BALLS_LEFT), 3);
            end
        end

        // Attract: auto serve at frame 64, no ball consumed, extra ignored
        ATTRACT = 1'b1;
        start(0, 3);
        frames(AUTO - 1);
        settle();
        chk("s4_frame63", int'(SERVE_WAIT), 1);
        frames(1);
        settle();
        chk("s4_frame64_reg", int'(SERVE_WAIT), 1);
        settle();
        chk("s4_auto_served", int'(SERVE_WAIT), 0);
        lose();
        chk("s4_no_consume", int'(BALLS_LEFT), 3);
        chk("s4_back_wait", int'(SERVE_WAIT), 1);
        step(0, 0, 0, 1, 0);
        settle();
        chk("s4_extra_ignored", int'(BALLS_LEFT), 3);
        ATTRACT = 1'b0;

        // Extra and loss together; saturation at MAX_BALLS
        start(0, 1);
        serve_ball();
        step(0, 0, 1, 1, 0);
        settle();
        chk("s5_net_zero", int'(BALLS_LEFT), 1);
        chk("s5_continue", int'(SERVE_WAIT), 1);
        chk("s5_egl", int'(EGL), 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
        settle();
        chk("s5_saturate", int'(BALLS_LEFT), 9);

        // Restart with player 2 in play, input clamping, then reset mid-game
        start(2, 1);
        serve_ball();
        lose();
        serve_ball();
        lose();
        serve_ball();
        chk("s6_player2", int'(PLAYER), 2);
        start(2, 5);
        chk("s6_restart_player", int'(PLAYER), 0);
        chk("s6_restart_balls", int'(BALLS_LEFT), 5);
        chk("s6_restart_wait", int'(SERVE_WAIT), 1);
        start(0, 0);
        chk("s6_clamp_zero", int'(BALLS_LEFT), 1);
        start(0, 15);
        chk("s6_clamp_max", int'(BALLS_LEFT), 9);
        serve_ball();
        @(posedge CLK_DRV);
        #2 RESET = 1'b1;
        settle();
        chk("s6_rst_egl", int'(EGL), 1);
        chk("s6_rst_balls", int'(BALLS_LEFT), 0);
        chk("s6_rst_wait", int'(SERVE_WAIT), 0);
        @(posedge CLK_DRV);
        #2 RESET = 1'b0;
        settle();

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
